// File: rtl/pe_ctrl_pkg.sv
// Shared types and default sizing for the PE feed controller and its global buffer.
package pe_ctrl_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 6;
    localparam int VEC_LEN = 16;
    localparam int TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_ISSUE) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/pe_gbuf.sv
// Global buffer: 2**AW words, one synchronous write port and one asynchronous read port.
// Latency: writes land on the next edge, reads are combinational; no backpressure.
module pe_gbuf #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic              aclk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // No reset: contents must survive a controller reset.
    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_feed_ctrl.sv
// Feeds one PE: loads VEC_LEN weights into its RAM, then issues operands one at a time.
// Latency: 16 load + (1 + wait) per element + 1 done; waits on pe_dvalid up to TIMEOUT cycles.
module pe_feed_ctrl #(
    parameter int DATA_W  = pe_ctrl_pkg::DATA_W,
    parameter int ADDR_W  = pe_ctrl_pkg::ADDR_W,
    parameter int VEC_LEN = pe_ctrl_pkg::VEC_LEN,
    parameter int TIMEOUT = pe_ctrl_pkg::TIMEOUT
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         start,
    input  logic                         gb_we,
    input  logic [$clog2(2*VEC_LEN)-1:0] gb_addr,
    input  logic [DATA_W-1:0]            gb_din,
    output logic [DATA_W-1:0]            pe_din,
    output logic [DATA_W-1:0]            pe_ain,
    output logic [ADDR_W-1:0]            pe_addr,
    output logic                         pe_we,
    output logic                         pe_valid,
    input  logic                         pe_dvalid,
    input  logic [DATA_W-1:0]            pe_dout,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [DATA_W-1:0]            result
);

    import pe_ctrl_pkg::*;

    localparam int IDX_W = $clog2(VEC_LEN);
    localparam int GBW   = IDX_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   j_q, j_d, k_q, k_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic               hit_last, to_hit;
    logic               gb_wr;
    logic [GBW-1:0]     rd_addr;
    logic [DATA_W-1:0]  rd_dat, rd_fwd;

    logic [DATA_W-1:0]  pe_din_d, pe_ain_d, result_d;
    logic [ADDR_W-1:0]  pe_addr_d;
    logic               pe_we_d, pe_valid_d, busy_d, done_d, err_d;

    // Host writes are only accepted while no run is using the buffer.
    assign gb_wr = gb_we & ~busy;

    pe_gbuf #(
        .DATA_W (DATA_W),
        .AW     (GBW)
    ) u_gbuf (
        .aclk  (aclk),
        .we    (gb_wr),
        .waddr (gb_addr),
        .wdata (gb_din),
        .raddr (rd_addr),
        .rdata (rd_dat)
    );

    // Weights live in the lower half, the ain vector in the upper half.
    assign rd_addr = (state_d == ST_LOAD) ? {1'b0, j_d} : {1'b1, k_d};

    // A write landing on the same edge as the read must be seen by it.
    assign rd_fwd = (gb_wr && (gb_addr == rd_addr)) ? gb_din : rd_dat;

    assign hit_last = (state_q == ST_WAIT) &&  pe_dvalid && (k_q == LAST_IDX);
    assign to_hit   = (state_q == ST_WAIT) && !pe_dvalid && (tcnt_q == TO_LAST);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            k_q     <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    j_d     = '0;
                end
            end
            ST_LOAD: begin
                if (j_q == LAST_IDX) begin
                    state_d = ST_ISSUE;
                    k_d     = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                tcnt_d  = '0;
            end
            ST_WAIT: begin
                if (pe_dvalid) begin
                    if (k_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        k_d     = k_q + 1'b1;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered copies line up with it.
    always_comb begin
        pe_we_d    = (state_d == ST_LOAD);
        pe_valid_d = (state_d == ST_ISSUE);
        busy_d     = is_busy(state_d);
        done_d     = (state_d == ST_DONE);
        pe_addr_d  = pe_addr;
        pe_din_d   = pe_din;
        pe_ain_d   = pe_ain;
        err_d      = err;
        result_d   = result;
        case (state_d)
            ST_LOAD: begin
                pe_addr_d = ADDR_W'(j_d);
                pe_din_d  = rd_fwd;
            end
            ST_ISSUE: begin
                pe_addr_d = ADDR_W'(k_d);
                pe_ain_d  = rd_fwd;
            end
            default: begin
            end
        endcase
        if ((state_q == ST_IDLE) && start) begin
            err_d = 1'b0;
        end
        if (to_hit) begin
            err_d = 1'b1;
        end
        if (hit_last) begin
            result_d = pe_dout;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pe_din   <= '0;
            pe_ain   <= '0;
            pe_addr  <= '0;
            pe_we    <= 1'b0;
            pe_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
        end else begin
            pe_din   <= pe_din_d;
            pe_ain   <= pe_ain_d;
            pe_addr  <= pe_addr_d;
            pe_we    <= pe_we_d;
            pe_valid <= pe_valid_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            result   <= result_d;
        end
    end

endmodule
